segment_transition_ctrl: RTL

- Generalised segment-switch controller shared by the modulation and STM paths.
- Owns the active segment index and applies host switch requests per transition mode (SYNC_IDX, SYS_TIME, GPIO, EXT).
- Counts loop repetitions and raises STOP for finite playback; in EXT mode it auto-advances through segments.
- Parametrised in segment count, repetition width, time width and GPIO count; one instance each in the modulation and STM blocks.

---
 rtl/segment_transition_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/segment_transition_ctrl.sv
`default_nettype none
//============================================================================
//  Module      : segment_transition_ctrl
//  Description : Segment-switch controller shared by the modulation and STM
//                paths. Owns the active segment index, applies host switch
//                requests according to their transition mode (SYNC_IDX,
//                SYS_TIME, GPIO, EXT), counts loop repetitions, raises STOP
//                for finite playback and auto-advances segments in EXT mode.
//
//  Ports       :
//    CLK              in   system clock (sole clock domain)
//    RST              in   synchronous active-high reset
//    REQ_VALID        in   one-cycle request strobe
//    REQ_SEGMENT      in   requested segment index
//    TRANSITION_MODE  in   0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT
//    TRANSITION_VALUE in   target time (SYS_TIME) or GPIO pin index (GPIO)
//    REP              in   per-segment repeat count (segment plays REP+1 loops)
//    LOOP_END         in   sampler pulse: current segment wrapped to index 0
//    SYS_TIME         in   free-running system time
//    GPIO_IN          in   synchronised GPIO trigger inputs
//    SEGMENT          out  active segment
//    UPDATE           out  one-cycle pulse on every segment switch
//    STOP             out  finite repetition exhausted
//    PENDING          out  accepted request waiting for its trigger
//    REQ_ERR          out  one-cycle pulse: request rejected
//
//  Revision    : 1.0  initial release
//============================================================================
module segment_transition_ctrl #(
    parameter int  NUM_SEGMENT = 2,
    parameter int  REP_WIDTH   = 16,
    parameter int  TIME_WIDTH  = 64,
    parameter int  NUM_GPIO    = 4,
    localparam int SEG_W       = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            REQ_VALID,
    input  logic [SEG_W-1:0]                REQ_SEGMENT,
    input  logic [7:0]                      TRANSITION_MODE,
    input  logic [TIME_WIDTH-1:0]           TRANSITION_VALUE,
    input  logic [NUM_SEGMENT*REP_WIDTH-1:0] REP,
    input  logic                            LOOP_END,
    input  logic [TIME_WIDTH-1:0]           SYS_TIME,
    input  logic [NUM_GPIO-1:0]             GPIO_IN,
    output logic [SEG_W-1:0]                SEGMENT,
    output logic                            UPDATE,
    output logic                            STOP,
    output logic                            PENDING,
    output logic                            REQ_ERR
);

    localparam int GPIO_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

    localparam logic [7:0]       c_mode_sync_idx = 8'h00;
    localparam logic [7:0]       c_mode_sys_time = 8'h01;
    localparam logic [7:0]       c_mode_gpio     = 8'h02;
    localparam logic [7:0]       c_mode_ext      = 8'hF0;

    localparam logic [SEG_W:0]   c_num_seg  = (SEG_W+1)'(NUM_SEGMENT);
    localparam logic [SEG_W-1:0] c_last_seg = SEG_W'(NUM_SEGMENT - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_WAIT_TIME = 2'd2,
        ST_WAIT_GPIO = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [SEG_W-1:0]        r_segment;
    logic                    r_update;
    logic                    r_stop;
    logic                    r_pending;
    logic                    r_req_err;
    logic [REP_WIDTH-1:0]    r_rep_cnt;
    logic                    r_ext_en;
    logic [SEG_W-1:0]        r_pend_seg;
    logic                    r_pend_ext;
    logic [TIME_WIDTH-1:0]   r_pend_value;
    logic [GPIO_W-1:0]       r_pend_pin;
    logic [NUM_GPIO-1:0]     r_gpio_prev;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                  w_state_nxt;
    logic [SEG_W-1:0]        w_segment_nxt;
    logic                    w_update_nxt;
    logic                    w_stop_nxt;
    logic                    w_pending_nxt;
    logic                    w_req_err_nxt;
    logic [REP_WIDTH-1:0]    w_rep_cnt_nxt;
    logic                    w_ext_en_nxt;
    logic [SEG_W-1:0]        w_pend_seg_nxt;
    logic                    w_pend_ext_nxt;
    logic [TIME_WIDTH-1:0]   w_pend_value_nxt;
    logic [GPIO_W-1:0]       w_pend_pin_nxt;

    // ------------------------------------------------------------------
    // Helper decode
    // ------------------------------------------------------------------
    logic [REP_WIDTH-1:0]    w_rep_cur;
    logic                    w_rep_inf;
    logic                    w_rep_done;
    logic                    w_gpio_rise;
    logic                    w_trigger;
    logic                    w_mode_known;
    logic                    w_seg_ok;
    logic [GPIO_W-1:0]       w_req_pin;

    assign w_rep_cur  = REP[r_segment*REP_WIDTH +: REP_WIDTH];
    assign w_rep_inf  = &w_rep_cur;
    // The loop that just ended was the last one of a finite repetition.
    assign w_rep_done = LOOP_END && (r_rep_cnt == w_rep_cur) && !w_rep_inf;

    // The edge detector follows the pins continuously, so a pin that is
    // already high when the request is accepted has to drop and rise again.
    assign w_gpio_rise = GPIO_IN[r_pend_pin] & ~r_gpio_prev[r_pend_pin];

    assign w_seg_ok  = ({1'b0, REQ_SEGMENT} < c_num_seg);
    // Pin index is reduced once at acceptance so the wait path only needs
    // a narrow mux select.
    assign w_req_pin = GPIO_W'(TRANSITION_VALUE % TIME_WIDTH'(NUM_GPIO));

    always_comb begin
        w_mode_known = 1'b0;
        case (TRANSITION_MODE)
            c_mode_sync_idx,
            c_mode_sys_time,
            c_mode_gpio,
            c_mode_ext:      w_mode_known = 1'b1;
            default:         w_mode_known = 1'b0;
        endcase
    end

    always_comb begin
        w_trigger = 1'b0;
        case (r_state)
            ST_WAIT_SYNC: w_trigger = LOOP_END;
            ST_WAIT_TIME: w_trigger = (SYS_TIME >= r_pend_value);
            ST_WAIT_GPIO: w_trigger = w_gpio_rise;
            default:      w_trigger = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_segment_nxt    = r_segment;
        w_update_nxt     = 1'b0;
        w_stop_nxt       = r_stop;
        w_pending_nxt    = r_pending;
        w_req_err_nxt    = 1'b0;
        w_rep_cnt_nxt    = r_rep_cnt;
        w_ext_en_nxt     = r_ext_en;
        w_pend_seg_nxt   = r_pend_seg;
        w_pend_ext_nxt   = r_pend_ext;
        w_pend_value_nxt = r_pend_value;
        w_pend_pin_nxt   = r_pend_pin;

        if (w_trigger) begin
            // A LOOP_END that fires a SYNC trigger is the switch itself and
            // is not counted as another loop of the outgoing segment.
            w_segment_nxt = r_pend_seg;
            w_update_nxt  = 1'b1;
            w_rep_cnt_nxt = '0;
            w_stop_nxt    = 1'b0;
            w_pending_nxt = 1'b0;
            w_state_nxt   = ST_RUN;
            if (r_pend_ext) begin
                w_ext_en_nxt = 1'b1;
            end
        end else begin
            // The current segment keeps counting even while a request waits.
            if (LOOP_END && !(&r_rep_cnt)) begin
                w_rep_cnt_nxt = r_rep_cnt + REP_WIDTH'(1);
            end
            if (w_rep_done) begin
                if (r_ext_en && (r_state == ST_RUN)) begin
                    w_segment_nxt = (r_segment == c_last_seg) ? '0
                                                              : r_segment + SEG_W'(1);
                    w_update_nxt  = 1'b1;
                    w_rep_cnt_nxt = '0;
                    w_stop_nxt    = 1'b0;
                end else begin
                    w_stop_nxt = 1'b1;
                end
            end
        end

        // A request is applied after any switch in the same cycle, so it
        // becomes the new pending request (or overwrites the old one).
        if (REQ_VALID) begin
            if (w_seg_ok && w_mode_known) begin
                w_pend_seg_nxt   = REQ_SEGMENT;
                w_pend_value_nxt = TRANSITION_VALUE;
                w_pend_pin_nxt   = w_req_pin;
                w_pend_ext_nxt   = (TRANSITION_MODE == c_mode_ext);
                w_pending_nxt    = 1'b1;
                if (TRANSITION_MODE != c_mode_ext) begin
                    w_ext_en_nxt = 1'b0;
                end
                case (TRANSITION_MODE)
                    c_mode_sys_time: w_state_nxt = ST_WAIT_TIME;
                    c_mode_gpio:     w_state_nxt = ST_WAIT_GPIO;
                    default:         w_state_nxt = ST_WAIT_SYNC;
                endcase
            end else begin
                w_req_err_nxt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_RUN;
            r_segment    <= '0;
            r_update     <= 1'b0;
            r_stop       <= 1'b0;
            r_pending    <= 1'b0;
            r_req_err    <= 1'b0;
            r_rep_cnt    <= '0;
            r_ext_en     <= 1'b0;
            r_pend_seg   <= '0;
            r_pend_ext   <= 1'b0;
            r_pend_value <= '0;
            r_pend_pin   <= '0;
            r_gpio_prev  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_segment    <= w_segment_nxt;
            r_update     <= w_update_nxt;
            r_stop       <= w_stop_nxt;
            r_pending    <= w_pending_nxt;
            r_req_err    <= w_req_err_nxt;
            r_rep_cnt    <= w_rep_cnt_nxt;
            r_ext_en     <= w_ext_en_nxt;
            r_pend_seg   <= w_pend_seg_nxt;
            r_pend_ext   <= w_pend_ext_nxt;
            r_pend_value <= w_pend_value_nxt;
            r_pend_pin   <= w_pend_pin_nxt;
            r_gpio_prev  <= GPIO_IN;
        end
    end

    assign SEGMENT = r_segment;
    assign UPDATE  = r_update;
    assign STOP    = r_stop;
    assign PENDING = r_pending;
    assign REQ_ERR = r_req_err;

endmodule
`default_nettype wire
